// File: rtl/rr_index_arbiter.sv
// Round-robin arbiter over 2**C level requesters; the winning index is held in a
// registered valid/ready slot that can reload on the same edge as a handshake.
module rr_index_arbiter #(
    parameter int unsigned C = 3,
    localparam int unsigned O = 1 << C
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [O-1:0] req,
    output logic [C-1:0] idx_o,
    output logic         valid_o,
    input  logic         ready_i,
    output logic [O-1:0] gnt_o
);

    typedef enum logic [0:0] {StEmpty, StFull} state_e;

    state_e       state_q;
    logic [C-1:0] ptr_q;
    logic [C-1:0] idx_q;

    logic [C-1:0] search_base;
    logic [C-1:0] win_idx;
    logic         any_req;
    logic         handshake;

    assign any_req   = |req;
    assign handshake = (state_q == StFull) && ready_i;

    // When FULL the only edge that consumes win_idx is a handshake, whose new
    // pointer is idx_q + 1, so the search can start there directly.
    always_comb begin
        logic         found;
        logic [C-1:0] cand;
        search_base = (state_q == StFull) ? idx_q + C'(1) : ptr_q;
        win_idx     = search_base;
        found       = 1'b0;
        cand        = search_base;
        for (int unsigned k = 0; k < O; k++) begin
            cand = search_base + C'(k);
            if (!found && req[cand]) begin
                win_idx = cand;
                found   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StEmpty;
            ptr_q   <= '0;
            idx_q   <= '0;
        end else begin
            case (state_q)
                StEmpty: begin
                    if (any_req) begin
                        idx_q   <= win_idx;
                        state_q <= StFull;
                    end
                end
                StFull: begin
                    if (ready_i) begin
                        ptr_q <= idx_q + C'(1);
                        if (any_req) begin
                            idx_q <= win_idx;
                        end else begin
                            state_q <= StEmpty;
                        end
                    end
                end
            endcase
        end
    end

    always_comb begin
        gnt_o = '0;
        if (handshake) begin
            gnt_o[idx_q] = 1'b1;
        end
    end

    assign idx_o   = idx_q;
    assign valid_o = (state_q == StFull);

endmodule

// File: tb/tb_rr_index_arbiter.sv
// Bench for rr_index_arbiter: directed scenarios on C=2, then randomized runs on
// C=1 and C=3 against a cyclic-search reference model.
module tb_rr_index_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic       rst1, rdy1, val1;
    logic [1:0] req1, gnt1;
    logic [0:0] idx1;

    logic       rst2, rdy2, val2;
    logic [3:0] req2, gnt2;
    logic [1:0] idx2;

    logic       rst3, rdy3, val3;
    logic [7:0] req3, gnt3;
    logic [2:0] idx3;

    rr_index_arbiter #(.C(1)) u_dut1 (
        .clk(clk), .rst(rst1), .req(req1), .idx_o(idx1),
        .valid_o(val1), .ready_i(rdy1), .gnt_o(gnt1)
    );

    rr_index_arbiter #(.C(2)) u_dut2 (
        .clk(clk), .rst(rst2), .req(req2), .idx_o(idx2),
        .valid_o(val2), .ready_i(rdy2), .gnt_o(gnt2)
    );

    rr_index_arbiter #(.C(3)) u_dut3 (
        .clk(clk), .rst(rst3), .req(req3), .idx_o(idx3),
        .valid_o(val3), .ready_i(rdy3), .gnt_o(gnt3)
    );

    task automatic edge2();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset2();
        rst2 = 1'b1;
        req2 = 4'b0000;
        rdy2 = 1'b0;
        edge2();
        rst2 = 1'b0;
    endtask

    task automatic test_reset();
        rst2 = 1'b1;
        req2 = 4'b1111;
        rdy2 = 1'b1;
        repeat (2) edge2();
        n_checks++;
        if (val2 !== 1'b0) begin
            n_fail++; $display("FAIL reset_valid: got %b expected 0", val2);
        end
        n_checks++;
        if (idx2 !== 2'd0) begin
            n_fail++; $display("FAIL reset_idx: got %0d expected 0", idx2);
        end
        n_checks++;
        if (gnt2 !== 4'b0000) begin
            n_fail++; $display("FAIL reset_gnt: got %b expected 0000", gnt2);
        end
    endtask

    task automatic test_alternate();
        logic [1:0] exp_idx;
        logic [3:0] exp_gnt;
        do_reset2();
        req2 = 4'b1010;
        rdy2 = 1'b1;
        #1;
        n_checks++;
        if (val2 !== 1'b0) begin
            n_fail++; $display("FAIL alt_first_valid: got %b expected 0", val2);
        end
        for (int k = 0; k < 4; k++) begin
            edge2();
            exp_idx = (k % 2 == 0) ? 2'd1 : 2'd3;
            exp_gnt = 4'b0001 << exp_idx;
            n_checks++;
            if (val2 !== 1'b1 || idx2 !== exp_idx || gnt2 !== exp_gnt) begin
                n_fail++;
                $display("FAIL alt_seq[%0d]: got v=%b idx=%0d gnt=%b expected v=1 idx=%0d gnt=%b",
                         k, val2, idx2, gnt2, exp_idx, exp_gnt);
            end
        end
    endtask

    task automatic test_sweep();
        logic [1:0] exp_idx;
        do_reset2();
        req2 = 4'b1111;
        rdy2 = 1'b1;
        for (int k = 0; k < 5; k++) begin
            edge2();
            exp_idx = 2'(k % 4);
            n_checks++;
            if (idx2 !== exp_idx || gnt2 !== (4'b0001 << exp_idx)) begin
                n_fail++;
                $display("FAIL sweep[%0d]: got idx=%0d gnt=%b expected idx=%0d gnt=%b",
                         k, idx2, gnt2, exp_idx, 4'b0001 << exp_idx);
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset2();
        req2 = 4'b0100;
        rdy2 = 1'b0;
        edge2();
        req2 = 4'b0001;
        for (int k = 0; k < 5; k++) begin
            edge2();
            n_checks++;
            if (idx2 !== 2'd2 || val2 !== 1'b1 || gnt2 !== 4'b0000) begin
                n_fail++;
                $display("FAIL stall[%0d]: got idx=%0d v=%b gnt=%b expected idx=2 v=1 gnt=0000",
                         k, idx2, val2, gnt2);
            end
        end
        rdy2 = 1'b1;
        #1;
        n_checks++;
        if (gnt2 !== 4'b0100) begin
            n_fail++; $display("FAIL stall_release_gnt: got %b expected 0100", gnt2);
        end
        edge2();
        n_checks++;
        if (idx2 !== 2'd0 || val2 !== 1'b1) begin
            n_fail++; $display("FAIL stall_next_idx: got idx=%0d v=%b expected idx=0 v=1", idx2, val2);
        end
    endtask

    task automatic test_drain();
        do_reset2();
        req2 = 4'b0100;
        rdy2 = 1'b1;
        edge2();
        req2 = 4'b0000;
        #1;
        n_checks++;
        if (val2 !== 1'b1 || idx2 !== 2'd2 || gnt2 !== 4'b0100) begin
            n_fail++;
            $display("FAIL drain_grant: got v=%b idx=%0d gnt=%b expected v=1 idx=2 gnt=0100",
                     val2, idx2, gnt2);
        end
        edge2();
        n_checks++;
        if (val2 !== 1'b0 || idx2 !== 2'd2 || gnt2 !== 4'b0000) begin
            n_fail++;
            $display("FAIL drain_empty: got v=%b idx=%0d gnt=%b expected v=0 idx=2 gnt=0000",
                     val2, idx2, gnt2);
        end
        edge2();
        n_checks++;
        if (val2 !== 1'b0) begin
            n_fail++; $display("FAIL drain_stay_empty: got v=%b expected 0", val2);
        end
        req2 = 4'b1001;
        edge2();
        n_checks++;
        if (idx2 !== 2'd3 || val2 !== 1'b1) begin
            n_fail++; $display("FAIL drain_ptr: got idx=%0d v=%b expected idx=3 v=1", idx2, val2);
        end
        edge2();
        n_checks++;
        if (idx2 !== 2'd0) begin
            n_fail++; $display("FAIL drain_wrap: got idx=%0d expected 0", idx2);
        end
    endtask

    task automatic test_reset_mid();
        do_reset2();
        req2 = 4'b1000;
        rdy2 = 1'b1;
        edge2();
        n_checks++;
        if (idx2 !== 2'd3 || gnt2 !== 4'b1000) begin
            n_fail++; $display("FAIL rmid_pre: got idx=%0d gnt=%b expected idx=3 gnt=1000", idx2, gnt2);
        end
        rst2 = 1'b1;
        edge2();
        n_checks++;
        if (val2 !== 1'b0 || idx2 !== 2'd0 || gnt2 !== 4'b0000) begin
            n_fail++;
            $display("FAIL rmid_reset: got v=%b idx=%0d gnt=%b expected v=0 idx=0 gnt=0000",
                     val2, idx2, gnt2);
        end
        rst2 = 1'b0;
        req2 = 4'b1000;
        #1;
        n_checks++;
        if (gnt2 !== 4'b0000) begin
            n_fail++; $display("FAIL empty_ready_gnt: got %b expected 0000", gnt2);
        end
        edge2();
        n_checks++;
        if (idx2 !== 2'd3 || val2 !== 1'b1) begin
            n_fail++; $display("FAIL rmid_after: got idx=%0d v=%b expected idx=3 v=1", idx2, val2);
        end
    endtask

    task automatic drive(input int c, input logic r, input logic [7:0] rq, input logic rd);
        case (c)
            1: begin rst1 = r; req1 = rq[1:0]; rdy1 = rd; end
            3: begin rst3 = r; req3 = rq;      rdy3 = rd; end
            default: begin rst2 = r; req2 = rq[3:0]; rdy2 = rd; end
        endcase
    endtask

    task automatic get_obs(input int c, output logic [7:0] oi, output logic ov,
                           output logic [7:0] og);
        case (c)
            1: begin oi = {7'b0, idx1}; ov = val1; og = {6'b0, gnt1}; end
            3: begin oi = {5'b0, idx3}; ov = val3; og = gnt3; end
            default: begin oi = {6'b0, idx2}; ov = val2; og = {4'b0, gnt2}; end
        endcase
    endtask

    // First requester at or after base, walking the ring of o positions.
    function automatic int pick(input logic [7:0] rq, input int base, input int o);
        for (int k = 0; k < o; k++) begin
            if (rq[(base + k) % o]) return (base + k) % o;
        end
        return 0;
    endfunction

    task automatic test_random(input int c, input int cycles);
        int         o;
        bit         m_full;
        int         m_idx, m_ptr;
        int         waits[8];
        logic [7:0] msk, rq, exp_gnt, oi, og, pi, pg;
        logic       ov, pv, rd, r, hs, starve_ok;
        o   = 1 << c;
        msk = 8'((1 << o) - 1);
        drive(c, 1'b1, 8'h00, 1'b0);
        @(posedge clk);
        m_full = 1'b0; m_idx = 0; m_ptr = 0;
        for (int i = 0; i < 8; i++) waits[i] = 0;
        rq = 8'h00;
        for (int cyc = 0; cyc < cycles; cyc++) begin
            @(negedge clk);
            rq = (rq ^ (8'($urandom) & 8'($urandom) & 8'($urandom))) & msk;
            if ($urandom_range(0, 15) == 0) rq = 8'h00;
            rd = ($urandom_range(0, 9) < 7);
            r  = ($urandom_range(0, 299) == 0);
            drive(c, r, rq, rd);
            #1;
            get_obs(c, oi, ov, og);
            exp_gnt = (m_full && rd) ? 8'(1 << m_idx) : 8'h00;
            n_checks++;
            if (ov !== m_full) begin
                n_fail++; $display("FAIL rnd_c%0d_valid @%0d: got %b expected %b", c, cyc, ov, m_full);
            end
            n_checks++;
            if (oi !== 8'(m_idx)) begin
                n_fail++; $display("FAIL rnd_c%0d_idx @%0d: got %0d expected %0d", c, cyc, oi, m_idx);
            end
            n_checks++;
            if (og !== exp_gnt) begin
                n_fail++; $display("FAIL rnd_c%0d_gnt @%0d: got %b expected %b", c, cyc, og, exp_gnt);
            end
            n_checks++;
            if ((og & (og - 8'd1)) !== 8'h00) begin
                n_fail++; $display("FAIL rnd_c%0d_onehot @%0d: got %b expected one-hot or zero",
                                   c, cyc, og);
            end
            // Outputs must not react to a mid-cycle req change.
            drive(c, r, ~rq & msk, rd);
            #1;
            get_obs(c, pi, pv, pg);
            n_checks++;
            if (pi !== 8'(m_idx) || pv !== m_full || pg !== exp_gnt) begin
                n_fail++;
                $display("FAIL rnd_c%0d_req_path @%0d: got idx=%0d v=%b gnt=%b expected idx=%0d v=%b gnt=%b",
                         c, cyc, pi, pv, pg, m_idx, m_full, exp_gnt);
            end
            drive(c, r, rq, rd);
            hs = m_full && rd && !r;
            starve_ok = 1'b1;
            for (int i = 0; i < o; i++) begin
                if (r || (hs && m_idx == i) || !rq[i]) waits[i] = 0;
                else if (hs) waits[i]++;
                if (waits[i] >= o) starve_ok = 1'b0;
            end
            if (hs) begin
                n_checks++;
                if (starve_ok !== 1'b1) begin
                    n_fail++; $display("FAIL rnd_c%0d_starve @%0d: got waiting>=%0d expected <%0d",
                                       c, cyc, o, o);
                end
            end
            if (r) begin
                m_full = 1'b0; m_ptr = 0; m_idx = 0;
            end else if (!m_full) begin
                if (rq != 8'h00) begin
                    m_idx  = pick(rq, m_ptr, o);
                    m_full = 1'b1;
                end
            end else if (rd) begin
                m_ptr = (m_idx + 1) % o;
                if (rq != 8'h00) m_idx = pick(rq, m_ptr, o);
                else m_full = 1'b0;
            end
        end
    endtask

    initial begin
        rst1 = 1'b1; req1 = '0; rdy1 = 1'b0;
        rst2 = 1'b1; req2 = '0; rdy2 = 1'b0;
        rst3 = 1'b1; req3 = '0; rdy3 = 1'b0;
        test_reset();
        test_alternate();
        test_sweep();
        test_backpressure();
        test_drain();
        test_reset_mid();
        test_random(1, 10000);
        test_random(3, 10000);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
